// File: rtl/cic_pkg.sv
// Constants and helpers shared by the CIC decimator and its compensation FIR.
// Coefficients are Q1.14, symmetric, and sum to exactly 2^14 so DC gain is unity.
package cic_pkg;

  localparam int SYS_CLK_FREQ   = 6_400_000;
  localparam int SAMPLE_RATE    = 800;

  localparam int CIC_COMP_NTAP  = 15;
  localparam int CIC_COMP_FRAC  = 14;
  localparam int CIC_COMP_NCOEF = 16;

  typedef logic signed [CIC_COMP_NCOEF-1:0] coef_t;

  // Alternating-sign side lobes lift the upper passband to undo the CIC droop.
  localparam coef_t CIC_COMP_COEF [CIC_COMP_NTAP] = '{
    -16'sd64,   16'sd96,  -16'sd192,  16'sd256, -16'sd512,  16'sd1024, -16'sd2048,
     16'sd19264,
    -16'sd2048, 16'sd1024, -16'sd512,  16'sd256, -16'sd192,  16'sd96,   -16'sd64
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } fir_state_e;

  // Round half up, drop frac bits, then clamp to a signed nout-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int frac,
                                                   input int nout);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (nout - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (nout - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Signed multiply-accumulate: one full-width product added into the accumulator per enabled clock.
module cic_comp_mac #(
  parameter int NA   = 16,
  parameter int NB   = 16,
  parameter int NACC = 40
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [NA-1:0]   a,
  input  logic signed [NB-1:0]   b,
  output logic signed [NACC-1:0] acc
);

  logic signed [NA+NB-1:0] prod;

  assign prod = a * b;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + NACC'(prod);
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Serial CIC compensation FIR: one tap per clock through a shared MAC, newest sample first,
// rounded and saturated output with a one-cycle valid strobe.
module cic_comp_fir
  import cic_pkg::*;
#(
  parameter int NIN   = 16,
  parameter int NOUT  = 16,
  parameter int NCOEF = CIC_COMP_NCOEF,
  parameter int NTAP  = CIC_COMP_NTAP,
  parameter int NACC  = 40,
  parameter int FRAC  = CIC_COMP_FRAC
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic signed [NIN-1:0]  din,
  output logic                   valid,
  output logic signed [NOUT-1:0] dout,
  output logic                   busy,
  output logic                   overrun
);

  localparam int PW = $clog2(NTAP);

  fir_state_e              state, state_nxt;
  logic signed [NIN-1:0]   buf_q [NTAP];
  logic [PW-1:0]           wptr, tap, rd_ptr;
  logic                    accept, last_tap, mac_clr, mac_en;
  logic signed [NIN-1:0]   x_rd;
  logic signed [NCOEF-1:0] h_rd;
  logic signed [NACC-1:0]  acc;

  assign accept   = en && (state == ST_IDLE);
  assign last_tap = (tap == PW'(NTAP - 1));
  assign busy     = (state == ST_MAC);

  // Circular read index (wptr - tap) mod NTAP; the PW-bit wrap keeps the second arm exact.
  assign rd_ptr = (wptr >= tap) ? wptr - tap : wptr + PW'(NTAP) - tap;
  assign x_rd   = buf_q[rd_ptr];
  assign h_rd   = NCOEF'(CIC_COMP_COEF[tap]);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    unique case (state)
      ST_IDLE: if (en) begin
        state_nxt = ST_MAC;
        mac_clr   = 1'b1;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (last_tap) state_nxt = ST_OUT;
      end
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      wptr    <= '0;
      tap     <= '0;
      valid   <= 1'b0;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= (state == ST_OUT);
      if (state == ST_OUT) dout <= NOUT'(sat_round(64'(acc), FRAC, NOUT));
      if (en && state != ST_IDLE) overrun <= 1'b1;
      if (state == ST_MAC) tap <= tap + PW'(1);
      else                 tap <= '0;
      if (state == ST_MAC && last_tap)
        wptr <= (wptr == PW'(NTAP - 1)) ? '0 : wptr + PW'(1);
    end
  end

  // NOTE: the sample buffer must read as zeros after reset, so it is a resettable register bank, not RAM.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NTAP; i++) buf_q[i] <= '0;
    end else if (accept) begin
      buf_q[wptr] <= din;
    end
  end

  cic_comp_mac #(
    .NA  (NIN),
    .NB  (NCOEF),
    .NACC(NACC)
  ) u_mac (
    .clk (clk),
    .rstn(rstn),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (x_rd),
    .b   (h_rd),
    .acc (acc)
  );

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: impulse, rounding, DC, saturation, overrun and mid-MAC reset.
module tb_cic_comp_fir;

  localparam int NTAP = 15;
  localparam int LAT  = NTAP + 2;
  localparam int COEF [NTAP] = '{-64, 96, -192, 256, -512, 1024, -2048, 19264,
                                 -2048, 1024, -512, 256, -192, 96, -64};
  localparam int EXP_D1 [NTAP] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  localparam int EXP_D4 [NTAP] = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0};
  localparam int EXP_D8 [NTAP] = '{0, 0, 0, 0, 0, 1, -1, 9, -1, 1, 0, 0, 0, 0, 0};

  logic               clk  = 1'b0;
  logic               rstn = 1'b0;
  logic               en   = 1'b0;
  logic signed [15:0] din  = '0;
  logic               valid, busy, overrun;
  logic signed [15:0] dout;

  int checks = 0;
  int errors = 0;
  int hist [NTAP];

  always #5 clk = ~clk;

  cic_comp_fir dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .din    (din),
    .valid  (valid),
    .dout   (dout),
    .busy   (busy),
    .overrun(overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_push(input int x);
    longint acc = 0;
    longint r;
    for (int k = NTAP - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    for (int k = 0; k < NTAP; k++) acc += longint'(hist[k]) * longint'(COEF[k]);
    r = (acc + 8192) >>> 14;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    en   = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < NTAP; k++) hist[k] = 0;
  endtask

  // Strobe one sample and wait (bounded) for its valid; latency is checked every time.
  task automatic run_sample(input string tag, input int x, output int y);
    int lat = -1;
    y = 0;
    @(negedge clk);
    en  = 1'b1;
    din = 16'(x);
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      en = 1'b0;
      if (valid) begin
        lat = i;
        y   = int'(dout);
      end
    end
    check({tag, "_lat"}, lat, LAT);
  endtask

  task automatic impulse_set(input string tag, input int amp, input int exp_tab [NTAP]);
    int y;
    for (int n = 0; n < NTAP; n++) begin
      run_sample(tag, (n == 0) ? amp : 0, y);
      void'(model_push((n == 0) ? amp : 0));
      check($sformatf("%s_%0d", tag, n), y, exp_tab[n]);
    end
  endtask

  initial begin
    int y, m, lat;
    bit seen;

    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int y, m, lat;
    bit seen;

    for (int k = 0; k < NTAP; k++) hist[k] = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    do_reset();

    // Impulse of 16384 reproduces the coefficient table; valid is one cycle and dout holds.
    for (int n = 0; n <= NTAP; n++) begin
      run_sample("imp", (n == 0) ? 16384 : 0, y);
      void'(model_push((n == 0) ? 16384 : 0));
      check($sformatf("imp_%0d", n), y, (n < NTAP) ? COEF[n] : 0);
      @(negedge clk);
      check("imp_valid_pulse", valid, 0);
      check("imp_hold", dout, y);
      repeat (80) @(negedge clk);
    end

    // Rounding: half-LSB cases at +0.5 (up to 1) and -0.5 (up to 0).
    impulse_set("rnd1", 1, EXP_D1);
    impulse_set("rnd4", 4, EXP_D4);
    impulse_set("rnd8", 8, EXP_D8);

    // DC, back-to-back strobes.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      run_sample("dcp", 1000, y);
      m = model_push(1000);
      check("dcp_model", y, m);
      if (n >= NTAP - 1) check($sformatf("dcp_%0d", n), y, 1000);
    end
    for (int n = 0; n < 20; n++) begin
      run_sample("dcn", -1000, y);
      m = model_push(-1000);
      check("dcn_model", y, m);
      if (n >= NTAP - 1) check($sformatf("dcn_%0d", n), y, -1000);
    end

    // Nyquist saturation.
    do_reset();
    for (int n = 0; n < 30; n++) begin
      run_sample("sat", (n % 2 == 0) ? 32767 : -32768, y);
      m = model_push((n % 2 == 0) ? 32767 : -32768);
      check($sformatf("sat_%0d", n), y, m);
      if (n == 28) check("sat_low", y, -32768);
      if (n == 29) check("sat_high", y, 32767);
    end

    // Overrun: second strobe 5 cycles in is dropped.
    do_reset();
    @(negedge clk);
    en  = 1'b1;
    din = 16'sd16384;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    check("ovr_busy", busy, 1);
    en  = 1'b1;
    din = 16'sd777;
    lat = -1;
    for (int i = 6; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      en = 1'b0;
      if (valid) begin
        lat = i;
        y   = int'(dout);
      end
    end
    void'(model_push(16384));
    check("ovr_lat", lat, LAT);
    check("ovr_first", y, -64);
    check("ovr_flag", overrun, 1);
    run_sample("ovr_next", 0, y);
    void'(model_push(0));
    check("ovr_next", y, 96);
    check("ovr_sticky", overrun, 1);

    // Reset mid-MAC with a primed buffer and overrun set.
    do_reset();
    run_sample("prime", 5000, y);
    check("prime", y, model_push(5000));
    @(negedge clk);
    en  = 1'b1;
    din = 16'sd16384;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en  = 1'b1;
    din = 16'sd123;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_ovr_set", overrun, 1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    check("mid_no_valid", seen, 0);
    check("mid_dout", dout, 0);
    check("mid_busy", busy, 0);
    check("mid_overrun", overrun, 0);
    for (int k = 0; k < NTAP; k++) hist[k] = 0;
    for (int n = 0; n < NTAP; n++) begin
      run_sample("post", (n == 0) ? 16384 : 0, y);
      check($sformatf("post_%0d", n), y, COEF[n]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
